// File: rtl/dm_lsu.sv
// Load/store initiator for the single-port data memory: byte-addressed requests become
// word accesses, sub-word stores go through read-modify-write, errors never touch DM.
module dm_lsu #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk_dm,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        Mem_Write,
    output logic [31:0] DM_Addr,
    output logic [31:0] M_W_Data,
    input  logic [31:0] M_R_Data
);
    localparam int NUM_LANES = 4;
    localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_STORE, S_RESP} state_t;

    // Only the low half of store data is needed after accept: SW data goes straight to wbuf.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [15:0] wdata;
    } req_t;

    state_t state, state_nx;
    req_t   req_q;
    logic   err_q;
    logic [31:0] wbuf, rdata_q, load_ext;
    logic   accept, req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [NUM_LANES-1:0]      lane_hit;
    logic [NUM_LANES-1:0][7:0] merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({1'b0, req_addr} >= DM_BYTES) req_err = 1'b1;
    end

    // Load lane extraction and extension
    assign byte_sel = M_R_Data[8*req_q.addr[1:0] +: 8];
    assign half_sel = req_q.addr[1] ? M_R_Data[31:16] : M_R_Data[15:0];

    always_comb begin
        case (req_q.size)
            2'b00:   load_ext = req_q.uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = req_q.uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = M_R_Data;
        endcase
    end

    // RMW merge: replace the addressed byte lane(s) of the read word
    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
        assign lane_hit[b] = (req_q.size == 2'b00) ? (req_q.addr[1:0] == 2'(b))
                                                   : (req_q.addr[1] == 1'(b / 2));
        assign merged[b] = !lane_hit[b] ? M_R_Data[8*b +: 8] :
                           ((req_q.size == 2'b00) || (b % 2 == 0)) ? req_q.wdata[7:0]
                                                                   : req_q.wdata[15:8];
    end

    always_ff @(posedge clk_dm) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) begin
                if (req_err)               state_nx = S_RESP;
                else if (!req_we)          state_nx = S_LOAD;
                else if (req_size == 2'b10) state_nx = S_STORE;
                else                       state_nx = S_RMW_RD;
            end
            S_LOAD:   state_nx = S_RESP;
            S_RMW_RD: state_nx = S_STORE;
            S_STORE:  state_nx = S_RESP;
            S_RESP:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_dm) begin
        if (!rst_n) begin
            req_q   <= '0;
            err_q   <= 1'b0;
            wbuf    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    req_q   <= '{we: req_we, size: req_size, uns: req_unsigned,
                                 addr: req_addr, wdata: req_wdata[15:0]};
                    err_q   <= req_err;
                    wbuf    <= req_wdata;
                    rdata_q <= '0;
                end
                S_LOAD:   rdata_q <= load_ext;
                S_RMW_RD: wbuf    <= merged;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        Mem_Write = 1'b0;
        DM_Addr   = '0;
        M_W_Data  = '0;
        case (state)
            S_IDLE:           req_ready = 1'b1;
            S_LOAD, S_RMW_RD: DM_Addr   = {2'b00, req_q.addr[31:2]};
            S_STORE: begin
                Mem_Write = 1'b1;
                DM_Addr   = {2'b00, req_q.addr[31:2]};
                M_W_Data  = wbuf;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (req_q.we || err_q) ? 32'd0 : rdata_q;
            end
            default: ;
        endcase
    end
endmodule
